// File: rtl/maxpool_flatten_pkg.sv
// maxpool_flatten_pkg: frame geometry, feature-buffer sizing and FSM encodings shared with the FC stage.
package maxpool_flatten_pkg;
    localparam int C_IN   = 16;
    localparam int H_IN   = 10;
    localparam int W_IN   = 10;
    localparam int DW     = 8;
    localparam int ADDR_W = 10;
    localparam int N_FEAT = C_IN * (H_IN / 2) * (W_IN / 2);
    localparam int CH_W   = $clog2(C_IN);
    localparam int ROW_W  = $clog2(H_IN);
    localparam int COL_W  = $clog2(W_IN);
    localparam logic [ADDR_W-1:0] CH_STRIDE  = ADDR_W'((H_IN / 2) * (W_IN / 2));
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(W_IN / 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    function automatic logic [ADDR_W-1:0] flat_addr(input logic [CH_W-1:0] c,
                                                    input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] k);
        return ADDR_W'(c) * CH_STRIDE + ADDR_W'(r >> 1) * ROW_STRIDE + ADDR_W'(k >> 1);
    endfunction
endpackage

// File: rtl/maxpool_flatten_if.sv
// maxpool_flatten_if: pixel stream in, flattened feature writes out, frame control/status.
interface maxpool_flatten_if;
    import maxpool_flatten_pkg::*;
    logic                     start;
    logic                     in_valid;
    logic signed [DW-1:0]     in_data;
    logic                     in_ready;
    logic                     feat_we;
    logic        [ADDR_W-1:0] feat_addr;
    logic signed [DW-1:0]     feat_data;
    logic                     busy;
    logic                     done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, feat_we, feat_addr, feat_data, busy, done
    );
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, feat_we, feat_addr, feat_data, busy, done
    );
endinterface

// File: rtl/maxpool_flatten_max2.sv
// max2_s8: combinational signed two-input maximum.
module max2_s8 #(
    parameter int DW = 8
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] y
);
    always_comb y = (a > b) ? a : b;
endmodule

// File: rtl/maxpool_flatten.sv
// maxpool_flatten: 2x2/stride-2 signed max-pool of a channel-major frame, flattened into the FC feature buffer.
// Define POOL_RELU_EN to clamp negative pooled features to zero before they are written.
module maxpool_flatten
    import maxpool_flatten_pkg::*;
(
    input logic clk,
    input logic reset,
    maxpool_flatten_if.slave bus
);
    state_t               state;
    logic [CH_W-1:0]      ch;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic [COL_W-2:0]     lb_idx;
    logic signed [DW-1:0] pair_reg;
    logic signed [DW-1:0] linebuf [W_IN/2];
    logic signed [DW-1:0] m, f, f_out;
    logic                 accept, col_end, row_end, last;

    assign lb_idx  = col[COL_W-1:1];
    assign accept  = (state == S_RUN) && bus.in_valid && bus.in_ready;
    assign col_end = col == COL_W'(W_IN - 1);
    assign row_end = row == ROW_W'(H_IN - 1);
    assign last    = col_end && row_end && (ch == CH_W'(C_IN - 1));

    // Horizontal max of the column pair, then vertical max against the buffered even row.
    max2_s8 #(.DW(DW)) u_pair (.a(pair_reg), .b(bus.in_data), .y(m));
    max2_s8 #(.DW(DW)) u_line (.a(linebuf[lb_idx]), .b(m), .y(f));

`ifdef POOL_RELU_EN
    always_comb f_out = f[DW-1] ? '0 : f;
`else
    always_comb f_out = f;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            bus.in_ready  <= 1'b0;
            bus.feat_we   <= 1'b0;
            bus.feat_addr <= '0;
            bus.feat_data <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            ch            <= '0;
            row           <= '0;
            col           <= '0;
            pair_reg      <= '0;
            for (int i = 0; i < W_IN / 2; i++) linebuf[i] <= '0;
        end else begin
            bus.feat_we <= 1'b0;
            bus.done    <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    state        <= S_RUN;
                    bus.busy     <= 1'b1;
                    bus.in_ready <= 1'b1;
                    ch           <= '0;
                    row          <= '0;
                    col          <= '0;
                end
                S_RUN: if (accept) begin
                    col <= col_end ? '0 : col + 1'b1;
                    if (col_end) row <= row_end ? '0 : row + 1'b1;
                    if (col_end && row_end) ch <= ch + 1'b1;
                    if (!col[0]) pair_reg <= bus.in_data;
                    else if (!row[0]) linebuf[lb_idx] <= m;
                    else begin
                        bus.feat_we   <= 1'b1;
                        bus.feat_addr <= flat_addr(ch, row, col);
                        bus.feat_data <= f_out;
                    end
                    if (last) begin
                        state        <= S_FLUSH;
                        bus.in_ready <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    state    <= S_DONE;
                    bus.done <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool_flatten.sv
// tb_maxpool_flatten: directed frames against the 2x2 max-pool/flatten stage; honours POOL_RELU_EN.
module tb_maxpool_flatten;
    import maxpool_flatten_pkg::*;

    localparam int N_PIX = C_IN * H_IN * W_IN;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    maxpool_flatten_if bus();
    maxpool_flatten dut (.clk(clk), .reset(reset), .bus(bus));

    int pass_cnt = 0, check_cnt = 0;
    logic signed [DW-1:0] pix [N_PIX];
    logic signed [DW-1:0] got [N_FEAT];
    int cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, last_we_cyc = 0, addr_bad = 0, exp_addr = 0;
    int last_acc, ready_bad, driven;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: capture writes by address, track sequencing and done pulses.
    always @(negedge clk) begin
        if (reset) exp_addr = 0;
        else begin
            if (bus.feat_we) begin
                if (int'(bus.feat_addr) < N_FEAT) got[bus.feat_addr] = bus.feat_data;
                if (int'(bus.feat_addr) != exp_addr) addr_bad++;
                exp_addr = (exp_addr == N_FEAT - 1) ? 0 : exp_addr + 1;
                wr_cnt++;
                last_we_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic signed [DW-1:0] model(input int k);
        int b;
        logic signed [DW-1:0] a0, a1, a2, a3, mx;
        b  = (k / 25) * 100 + ((k % 25) / 5) * 20 + (k % 5) * 2;
        a0 = pix[b]; a1 = pix[b + 1]; a2 = pix[b + 10]; a3 = pix[b + 11];
        mx = a0;
        if (a1 > mx) mx = a1;
        if (a2 > mx) mx = a2;
        if (a3 > mx) mx = a3;
`ifdef POOL_RELU_EN
        if (mx < 0) mx = 0;
`endif
        return mx;
    endfunction

    function automatic int mism();
        int n = 0;
        for (int k = 0; k < N_FEAT; k++) if (got[k] !== model(k)) n++;
        return n;
    endfunction

    task automatic drive_frame(input int duty, input int restart_at, input int abort_at);
        int idx = 0, guard = 0;
        ready_bad = 0;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        while (idx < N_PIX && guard < 20000) begin
            if (idx == abort_at) begin
                reset = 1'b1;
                bus.in_valid = 1'b0;
                @(posedge clk); #1 reset = 1'b0;
                driven = idx;
                return;
            end
            bus.start    = (idx == restart_at);
            bus.in_valid = ($urandom_range(99) < duty);
            bus.in_data  = pix[idx];
            @(negedge clk);
            if (!bus.in_ready) ready_bad++;
            if (bus.in_valid && bus.in_ready) begin
                idx++;
                if (idx == N_PIX) last_acc = cyc;
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        driven = idx;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b expected 0", bus.in_ready); else pass_cnt++;
        check_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b expected 0", bus.busy); else pass_cnt++;
        check_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %0b expected 0", bus.done); else pass_cnt++;
        check_cnt++; if (bus.feat_we !== 1'b0) $display("FAIL reset_feat_we got %0b expected 0", bus.feat_we); else pass_cnt++;
        check_cnt++; if (bus.feat_addr !== '0) $display("FAIL reset_feat_addr got %0d expected 0", bus.feat_addr); else pass_cnt++;
        check_cnt++; if (bus.feat_data !== '0) $display("FAIL reset_feat_data got %0d expected 0", bus.feat_data); else pass_cnt++;
    endtask

    task automatic test_idle;
        int w0 = wr_cnt, rdy = 0, bsy = 0;
        @(posedge clk); #1 bus.in_valid = 1'b1; bus.in_data = 8'sd55;
        repeat (8) begin
            @(negedge clk);
            if (bus.in_ready) rdy++;
            if (bus.busy) bsy++;
        end
        @(posedge clk); #1 bus.in_valid = 1'b0;
        check_cnt++; if (rdy != 0) $display("FAIL idle_in_ready got %0d ready cycles expected 0", rdy); else pass_cnt++;
        check_cnt++; if (wr_cnt != w0) $display("FAIL idle_writes got %0d expected 0", wr_cnt - w0); else pass_cnt++;
        check_cnt++; if (bsy != 0) $display("FAIL idle_busy got %0d busy cycles expected 0", bsy); else pass_cnt++;
    endtask

    task automatic test_ramp;
        int w0 = wr_cnt, d0 = done_cnt, a0 = addr_bad, mm;
        for (int i = 0; i < N_PIX; i++) pix[i] = DW'(i % 128);
        drive_frame(100, -1, -1);
        wait_done(d0);
        mm = mism();
        check_cnt++; if (wr_cnt - w0 != 400) $display("FAIL ramp_writes got %0d expected 400", wr_cnt - w0); else pass_cnt++;
        check_cnt++; if (done_cnt - d0 != 1) $display("FAIL ramp_done_count got %0d expected 1", done_cnt - d0); else pass_cnt++;
        check_cnt++; if (last_we_cyc != last_acc + 1) $display("FAIL ramp_last_we_cycle got %0d expected %0d", last_we_cyc, last_acc + 1); else pass_cnt++;
        check_cnt++; if (done_cyc != last_acc + 2) $display("FAIL ramp_done_cycle got %0d expected %0d", done_cyc, last_acc + 2); else pass_cnt++;
        check_cnt++; if (addr_bad != a0) $display("FAIL ramp_addr_seq got %0d bad expected 0", addr_bad - a0); else pass_cnt++;
        check_cnt++; if (got[0] !== 8'sd11) $display("FAIL ramp_addr0 got %0d expected 11", got[0]); else pass_cnt++;
        check_cnt++; if (got[24] !== 8'sd99) $display("FAIL ramp_addr24 got %0d expected 99", got[24]); else pass_cnt++;
        check_cnt++; if (got[25] !== 8'sd111) $display("FAIL ramp_addr25 got %0d expected 111", got[25]); else pass_cnt++;
        check_cnt++; if (got[50] !== 8'sd83) $display("FAIL ramp_addr50 got %0d expected 83", got[50]); else pass_cnt++;
        check_cnt++; if (mm != 0) $display("FAIL ramp_model got %0d mismatches expected 0", mm); else pass_cnt++;
        check_cnt++; if (bus.busy !== 1'b0) $display("FAIL ramp_busy_after got %0b expected 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_negative;
        int d0 = done_cnt;
        logic signed [DW-1:0] e_win, e_oth;
`ifdef POOL_RELU_EN
        e_win = 8'sd0; e_oth = 8'sd0;
`else
        e_win = -8'sd1; e_oth = -8'sd5;
`endif
        for (int i = 0; i < N_PIX; i++) pix[i] = -8'sd5;
        pix[144] = -8'sd128; pix[145] = -8'sd1; pix[154] = -8'sd7; pix[155] = -8'sd3;
        drive_frame(100, -1, -1);
        wait_done(d0);
        check_cnt++; if (got[37] !== e_win) $display("FAIL neg_window got %0d expected %0d", got[37], e_win); else pass_cnt++;
        check_cnt++; if (got[0] !== e_oth) $display("FAIL neg_addr0 got %0d expected %0d", got[0], e_oth); else pass_cnt++;
        check_cnt++; if (got[399] !== e_oth) $display("FAIL neg_addr399 got %0d expected %0d", got[399], e_oth); else pass_cnt++;
        check_cnt++; if (got[36] !== e_oth) $display("FAIL neg_addr36 got %0d expected %0d", got[36], e_oth); else pass_cnt++;
    endtask

    task automatic test_random_gaps;
        int w0 = wr_cnt, d0 = done_cnt, a0 = addr_bad, mm;
        for (int i = 0; i < N_PIX; i++) pix[i] = DW'($urandom_range(255));
        drive_frame(30, -1, -1);
        wait_done(d0);
        mm = mism();
        check_cnt++; if (mm != 0) $display("FAIL rand_model got %0d mismatches expected 0", mm); else pass_cnt++;
        check_cnt++; if (ready_bad != 0) $display("FAIL rand_in_ready got %0d low cycles expected 0", ready_bad); else pass_cnt++;
        check_cnt++; if (addr_bad != a0) $display("FAIL rand_addr_seq got %0d bad expected 0", addr_bad - a0); else pass_cnt++;
        check_cnt++; if (wr_cnt - w0 != 400) $display("FAIL rand_writes got %0d expected 400", wr_cnt - w0); else pass_cnt++;
        check_cnt++; if (done_cyc != last_acc + 2) $display("FAIL rand_done_cycle got %0d expected %0d", done_cyc, last_acc + 2); else pass_cnt++;
    endtask

    task automatic test_restart_ignored;
        int w0 = wr_cnt, d0 = done_cnt, mm;
        for (int i = 0; i < N_PIX; i++) pix[i] = DW'($urandom_range(255));
        drive_frame(100, 300, -1);
        wait_done(d0);
        mm = mism();
        check_cnt++; if (wr_cnt - w0 != 400) $display("FAIL restart_writes got %0d expected 400", wr_cnt - w0); else pass_cnt++;
        check_cnt++; if (done_cnt - d0 != 1) $display("FAIL restart_done_count got %0d expected 1", done_cnt - d0); else pass_cnt++;
        check_cnt++; if (mm != 0) $display("FAIL restart_model got %0d mismatches expected 0", mm); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int d0 = done_cnt, w0, a0, mm;
        for (int i = 0; i < N_PIX; i++) pix[i] = DW'($urandom_range(255));
        drive_frame(100, -1, 750);
        repeat (10) @(negedge clk);
        check_cnt++; if (done_cnt != d0) $display("FAIL abort_done got %0d pulses expected 0", done_cnt - d0); else pass_cnt++;
        check_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %0b expected 0", bus.busy); else pass_cnt++;
        w0 = wr_cnt; a0 = addr_bad;
        for (int i = 0; i < N_PIX; i++) pix[i] = DW'($urandom_range(255));
        drive_frame(100, -1, -1);
        wait_done(d0);
        mm = mism();
        check_cnt++; if (done_cnt - d0 != 1) $display("FAIL rerun_done_count got %0d expected 1", done_cnt - d0); else pass_cnt++;
        check_cnt++; if (wr_cnt - w0 != 400) $display("FAIL rerun_writes got %0d expected 400", wr_cnt - w0); else pass_cnt++;
        check_cnt++; if (addr_bad != a0) $display("FAIL rerun_addr_seq got %0d bad expected 0", addr_bad - a0); else pass_cnt++;
        check_cnt++; if (mm != 0) $display("FAIL rerun_model got %0d mismatches expected 0", mm); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_idle;
        test_ramp;
        test_negative;
        test_random_gaps;
        test_restart_ignored;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
